// File: rtl/scale_adapt.sv
// scale_adapt: ADPCM quantizer scale-factor adaptation.
// One request runs IDLE -> ADAPT -> MULT (7 cycles) -> MIX -> IDLE.
// ADAPT updates the fast (YU) and slow (YL) scale factors from the code word.
// MULT forms DIFM*AL with a shift-add multiplier, one AL bit per cycle.
// MIX blends the two factors into the new quantizer scale Y.
module scale_adapt #(
   parameter logic [12:0] YU_RST = 13'd544,
   parameter logic [18:0] YL_RST = 19'd34816
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [4:0]  I,
   input  logic [1:0]  RATE,
   input  logic [6:0]  AL,
   output logic        BUSY,
   output logic        DONE,
   output logic [12:0] Y,
   output logic [18:0] YL
);

   typedef enum logic [1:0] {IDLE, ADAPT, MULT, MIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  i_q, i_d;
   logic [1:0]  rate_q, rate_d;
   logic [6:0]  al_q, al_d;      // shifted right once per MULT cycle
   logic [2:0]  cnt_q, cnt_d;    // MULT cycle index = weight of current AL bit
   logic [19:0] acc_q, acc_d;    // exact DIFM*AL product
   logic [12:0] yu_q, yu_d;
   logic [18:0] yl_q, yl_d;
   logic [12:0] y_q, y_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [3:0]         im;
   logic signed [11:0] wi;
   logic [16:0]        wi32, dif;
   logic [12:0]        difsx, yut, yu_new;
   logic [20:0]        yl_sh;
   logic [13:0]        d2;
   logic [18:0]        yl_new;
   logic [13:0]        dm;
   logic               s;
   logic [12:0]        difm, prodm, yl_hi, y_mix;
   logic [13:0]        pm14;
   logic [19:0]        pp;
   logic [6:0]         al_clamp;

   // Sign/magnitude split of the active code field, then WI table lookup
   always_comb begin
      im = 4'd0;
      unique case (rate_q)
         2'b00: im = i_q[1] ? {3'b000, ~i_q[0]}   : {3'b000, i_q[0]};
         2'b01: im = i_q[2] ? {2'b00, ~i_q[1:0]}  : {2'b00, i_q[1:0]};
         2'b10: im = i_q[3] ? {1'b0, ~i_q[2:0]}   : {1'b0, i_q[2:0]};
         2'b11: im = i_q[4] ? ~i_q[3:0]           : i_q[3:0];
      endcase
      wi = 12'sd0;
      unique case (rate_q)
         2'b00: wi = im[0] ? 12'sd439 : -12'sd22;
         2'b01:
            case (im[1:0])
               2'd0: wi = -12'sd4;
               2'd1: wi = 12'sd30;
               2'd2: wi = 12'sd137;
               default: wi = 12'sd582;
            endcase
         2'b10:
            case (im[2:0])
               3'd0: wi = -12'sd12;
               3'd1: wi = 12'sd18;
               3'd2: wi = 12'sd41;
               3'd3: wi = 12'sd64;
               3'd4: wi = 12'sd112;
               3'd5: wi = 12'sd198;
               3'd6: wi = 12'sd355;
               default: wi = 12'sd1122;
            endcase
         2'b11:
            case (im)
               4'd0:  wi = 12'sd14;
               4'd1:  wi = 12'sd14;
               4'd2:  wi = 12'sd24;
               4'd3:  wi = 12'sd39;
               4'd4:  wi = 12'sd40;
               4'd5:  wi = 12'sd41;
               4'd6:  wi = 12'sd58;
               4'd7:  wi = 12'sd100;
               4'd8:  wi = 12'sd141;
               4'd9:  wi = 12'sd179;
               4'd10: wi = 12'sd219;
               4'd11: wi = 12'sd280;
               4'd12: wi = 12'sd358;
               4'd13: wi = 12'sd440;
               4'd14: wi = 12'sd529;
               default: wi = 12'sd696;
            endcase
      endcase
   end

   // Scale-factor datapath: adaptation, mix term, multiplier step, final mix
   always_comb begin
      // WI*32 wraps naturally in 17 bits, so adding 2^17 is a no-op
      wi32   = {wi, 5'b00000};
      dif    = wi32 - {4'b0000, y_q};
      difsx  = 13'(dif >> 5) + (dif[16] ? 13'd4096 : 13'd0);
      yut    = y_q + difsx;
      yu_new = (yut < 13'd544) ? 13'd544 : ((yut > 13'd5120) ? 13'd5120 : yut);
      yl_sh  = 21'd1048576 - {2'b00, yl_q};
      d2     = 14'({2'b00, yu_new} + 15'(yl_sh >> 6));
      // D2 is a signed 14-bit step; sign-extend it into YL
      yl_new = yl_q + {{5{d2[13]}}, d2};

      // Mix term uses the freshly registered YU/YL, stable through MULT
      yl_hi  = 13'(yl_q >> 6);
      dm     = {1'b0, yu_q} - {1'b0, yl_hi};
      s      = dm[13];
      difm   = s ? 13'(14'd0 - dm) : dm[12:0];

      pp     = al_q[0] ? (20'(difm) << cnt_q) : 20'd0;

      prodm  = 13'(acc_q >> 6);
      pm14   = s ? (14'd0 - {1'b0, prodm}) : {1'b0, prodm};
      y_mix  = 13'({1'b0, yl_hi} + pm14);

      al_clamp = (AL > 7'd64) ? 7'd64 : AL;
   end

   // Next-state and next-register logic of the request sequencer
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      rate_d  = rate_q;
      al_d    = al_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      yu_d    = yu_q;
      yl_d    = yl_q;
      y_d     = y_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               i_d     = I;
               rate_d  = RATE;
               al_d    = al_clamp;
               acc_d   = 20'd0;
               cnt_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = ADAPT;
            end
         end
         ADAPT: begin
            yu_d    = yu_new;
            yl_d    = yl_new;
            acc_d   = 20'd0;
            cnt_d   = 3'd0;
            state_d = MULT;
         end
         MULT: begin
            acc_d = acc_q + pp;
            al_d  = al_q >> 1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) state_d = MIX;
         end
         MIX: begin
            y_d     = y_mix;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any request in flight
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         i_q     <= 5'd0;
         rate_q  <= 2'd0;
         al_q    <= 7'd0;
         cnt_q   <= 3'd0;
         acc_q   <= 20'd0;
         yu_q    <= YU_RST;
         yl_q    <= YL_RST;
         y_q     <= 13'd544;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         rate_q  <= rate_d;
         al_q    <= al_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         yu_q    <= yu_d;
         yl_q    <= yl_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign Y    = y_q;
   assign YL   = yl_q;

endmodule

// File: tb/tb_scale_adapt.sv
// Directed bench for scale_adapt with hand-computed expected values.
module tb_scale_adapt;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        START = 1'b0;
   logic [4:0]  I = 5'd0;
   logic [1:0]  RATE = 2'd0;
   logic [6:0]  AL = 7'd0;
   logic        BUSY, DONE;
   logic [12:0] Y;
   logic [18:0] YL;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int prev_y;
   int seen;

   always #5 CLK = ~CLK;

   scale_adapt dut (
      .CLK(CLK), .RESET(RESET), .START(START), .I(I), .RATE(RATE), .AL(AL),
      .BUSY(BUSY), .DONE(DONE), .Y(Y), .YL(YL)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("%s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      START = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
   endtask

   // Issue one request and wait (bounded) for DONE; lat counts edges from accept
   task automatic run_req(input logic [1:0] r, input logic [4:0] i, input logic [6:0] al,
                          output int l);
      @(negedge CLK);
      START = 1'b1; RATE = r; I = i; AL = al;
      @(negedge CLK);
      START = 1'b0;
      l = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CLK);
         if (DONE) begin l = n; break; end
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_y", 32'(Y), 544);
      check("rst_yl", 32'(YL), 34816);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_done", 32'(DONE), 0);

      // 32k, I=0111 (WI=1122), AL=0, with per-cycle timing checks
      @(negedge CLK);
      START = 1'b1; RATE = 2'b10; I = 5'b00111; AL = 7'd0;
      @(negedge CLK);
      START = 1'b0;
      check("acc_busy", 32'(BUSY), 1);
      check("acc_yl_unchanged", 32'(YL), 34816);
      @(negedge CLK);
      check("adapt_yl", 32'(YL), 35921);
      check("adapt_y_unchanged", 32'(Y), 544);
      lat = -1;
      for (int n = 2; n <= 20; n++) begin
         @(negedge CLK);
         if (DONE) begin lat = n; break; end
      end
      check("al0_latency", 32'(lat), 9);
      check("al0_y", 32'(Y), 561);
      check("al0_busy_at_done", 32'(BUSY), 0);
      @(negedge CLK);
      check("al0_done_pulse", 32'(DONE), 0);
      check("al0_y_hold", 32'(Y), 561);

      // Negative WI and S=1 mix path from the state left above
      run_req(2'b10, 5'b01111, 7'd32, lat);
      check("neg_latency", 32'(lat), 9);
      check("neg_y", 32'(Y), 552);
      check("neg_yl", 32'(YL), 35903);

      // AL=64
      do_reset();
      run_req(2'b10, 5'b00111, 7'd64, lat);
      check("al64_y", 32'(Y), 1649);
      check("al64_yl", 32'(YL), 35921);

      // Lower clamp
      do_reset();
      run_req(2'b10, 5'b00000, 7'd0, lat);
      check("lo_clamp_y", 32'(Y), 544);
      check("lo_clamp_yl", 32'(YL), 34816);

      // 24k table, sign=1 path, AL above 64 clamped
      do_reset();
      run_req(2'b01, 5'b00110, 7'd100, lat);
      check("r24_y", 32'(Y), 557);
      check("r24_yl", 32'(YL), 34829);

      // Upper clamp with the 40k table over 200 requests
      do_reset();
      prev_y = 544;
      for (int k = 0; k < 200; k++) begin
         run_req(2'b11, 5'b01111, 7'd64, lat);
         check("up_done", 32'(lat), 9);
         check("up_mono", 32'((int'(Y) >= prev_y) ? 1 : 0), 1);
         check("up_max", 32'((Y <= 13'd5120) ? 1 : 0), 1);
         prev_y = int'(Y);
      end
      check("up_final", 32'(Y), 5120);

      // START pulses during MULT are ignored
      do_reset();
      @(negedge CLK);
      START = 1'b1; RATE = 2'b10; I = 5'b00111; AL = 7'd0;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      START = 1'b1; I = 5'b00000; AL = 7'd64;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CLK);
         if (DONE) begin lat = n; break; end
      end
      check("ign_done_seen", 32'((lat > 0) ? 1 : 0), 1);
      check("ign_y", 32'(Y), 561);
      check("ign_yl", 32'(YL), 35921);
      seen = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge CLK);
         if (BUSY || DONE) seen++;
      end
      check("ign_not_queued", 32'(seen), 0);

      // Reset mid-MULT, together with START
      @(negedge CLK);
      START = 1'b1; RATE = 2'b10; I = 5'b00111; AL = 7'd0;
      @(negedge CLK);
      START = 1'b0;
      repeat (4) @(negedge CLK);
      RESET = 1'b1; START = 1'b1;
      @(negedge CLK);
      RESET = 1'b0; START = 1'b0;
      check("abort_busy", 32'(BUSY), 0);
      check("abort_y", 32'(Y), 544);
      check("abort_yl", 32'(YL), 34816);
      check("abort_done", 32'(DONE), 0);
      seen = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge CLK);
         if (BUSY || DONE) seen++;
      end
      check("abort_quiet", 32'(seen), 0);

      // Fresh request after abort behaves like a clean one
      run_req(2'b10, 5'b00111, 7'd0, lat);
      check("post_latency", 32'(lat), 9);
      check("post_y", 32'(Y), 561);
      check("post_yl", 32'(YL), 35921);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
